// File: rtl/twiddle_mult_stage.sv
// rtl/twiddle_mult_stage.sv - pipelined complex twiddle multiplier for a three-input FFT combining stage
//
// Three complex samples enter per valid cycle. Sample 1 is delay-matched;
// samples 2 and 3 are multiplied by W^k and W^(2k) from an external
// synchronous ROM addressed by tw_addr. Results are rounded (half toward
// +inf), saturated and registered, and appear 3 cycles after in_valid.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, frame_start     input qualifier, restart twiddle index at 0
//   Re_i1..Im_i3              input samples (bit_width, signed)
//   tw_addr                   twiddle index k for the current input (comb)
//   Re_w2..Im_w3              ROM data W^k, W^(2k), one cycle after tw_addr
//   Re_o1..Im_o3              registered results (bit_width, signed)
//   out_valid, ovf            result strobe, saturation flag for the triple
module twiddle_mult_stage #(
  parameter int bit_width      = 16,
  parameter int word_length_tw = 14,
  parameter int frame_len      = 16,
  parameter int addr_w         = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      frame_start,
  input  logic [bit_width-1:0]      Re_i1,
  input  logic [bit_width-1:0]      Im_i1,
  input  logic [bit_width-1:0]      Re_i2,
  input  logic [bit_width-1:0]      Im_i2,
  input  logic [bit_width-1:0]      Re_i3,
  input  logic [bit_width-1:0]      Im_i3,
  output logic [addr_w-1:0]         tw_addr,
  input  logic [word_length_tw-1:0] Re_w2,
  input  logic [word_length_tw-1:0] Im_w2,
  input  logic [word_length_tw-1:0] Re_w3,
  input  logic [word_length_tw-1:0] Im_w3,
  output logic [bit_width-1:0]      Re_o1,
  output logic [bit_width-1:0]      Im_o1,
  output logic [bit_width-1:0]      Re_o2,
  output logic [bit_width-1:0]      Im_o2,
  output logic [bit_width-1:0]      Re_o3,
  output logic [bit_width-1:0]      Im_o3,
  output logic                      out_valid,
  output logic                      ovf
);

  localparam int pw = bit_width + word_length_tw;
  localparam logic signed [pw:0] rnd_half = (pw+1)'(2 ** (word_length_tw - 3));
  localparam logic signed [pw:0] sat_max  = (pw+1)'(2 ** (bit_width - 1) - 1);
  localparam logic signed [pw:0] sat_min  = (pw+1)'(-(2 ** (bit_width - 1)));

  // Returns {saturated, value}.
  function automatic logic [bit_width:0] round_sat(input logic signed [pw:0] x);
    logic signed [pw:0] r;
    r = (x + rnd_half) >>> (word_length_tw - 2);
    if (r > sat_max)      round_sat = {1'b1, sat_max[bit_width-1:0]};
    else if (r < sat_min) round_sat = {1'b1, sat_min[bit_width-1:0]};
    else                  round_sat = {1'b0, r[bit_width-1:0]};
  endfunction

  // Twiddle index: frame_len is a power of two so the +1 wraps naturally.
  logic [addr_w-1:0] k;
  assign tw_addr = (frame_start && in_valid) ? '0 : k;

  always_ff @(posedge clk) begin
    if (rst)           k <= '0;
    else if (in_valid) k <= tw_addr + addr_w'(1);
  end

  // S0: input capture
  logic                        v0;
  logic signed [bit_width-1:0] s0_re1, s0_im1, s0_re2, s0_im2, s0_re3, s0_im3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      s0_re1 <= '0; s0_im1 <= '0; s0_re2 <= '0;
      s0_im2 <= '0; s0_re3 <= '0; s0_im3 <= '0;
    end else begin
      v0 <= in_valid;
      if (in_valid) begin
        s0_re1 <= Re_i1; s0_im1 <= Im_i1; s0_re2 <= Re_i2;
        s0_im2 <= Im_i2; s0_re3 <= Re_i3; s0_im3 <= Im_i3;
      end
    end
  end

  // S1: real products; the ROM word for this sample is on the bus now
  logic signed [word_length_tw-1:0] w2r, w2i, w3r, w3i;
  assign w2r = Re_w2;
  assign w2i = Im_w2;
  assign w3r = Re_w3;
  assign w3i = Im_w3;

  logic                        v1;
  logic signed [bit_width-1:0] d1_re, d1_im;
  logic signed [pw-1:0]        p2_ac, p2_bd, p2_ad, p2_bc;
  logic signed [pw-1:0]        p3_ac, p3_bd, p3_ad, p3_bc;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1_re <= '0; d1_im <= '0;
      p2_ac <= '0; p2_bd <= '0; p2_ad <= '0; p2_bc <= '0;
      p3_ac <= '0; p3_bd <= '0; p3_ad <= '0; p3_bc <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        d1_re <= s0_re1;
        d1_im <= s0_im1;
        p2_ac <= pw'(s0_re2) * pw'(w2r);
        p2_bd <= pw'(s0_im2) * pw'(w2i);
        p2_ad <= pw'(s0_re2) * pw'(w2i);
        p2_bc <= pw'(s0_im2) * pw'(w2r);
        p3_ac <= pw'(s0_re3) * pw'(w3r);
        p3_bd <= pw'(s0_im3) * pw'(w3i);
        p3_ad <= pw'(s0_re3) * pw'(w3i);
        p3_bc <= pw'(s0_im3) * pw'(w3r);
      end
    end
  end

  // S2: combine at pw+1 bits, round, saturate
  logic signed [pw:0]   re2_full, im2_full, re3_full, im3_full;
  logic [bit_width:0]   re2_rs, im2_rs, re3_rs, im3_rs;

  assign re2_full = (pw+1)'(p2_ac) - (pw+1)'(p2_bd);
  assign im2_full = (pw+1)'(p2_ad) + (pw+1)'(p2_bc);
  assign re3_full = (pw+1)'(p3_ac) - (pw+1)'(p3_bd);
  assign im3_full = (pw+1)'(p3_ad) + (pw+1)'(p3_bc);
  assign re2_rs   = round_sat(re2_full);
  assign im2_rs   = round_sat(im2_full);
  assign re3_rs   = round_sat(re3_full);
  assign im3_rs   = round_sat(im3_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ovf <= 1'b0;
      Re_o1 <= '0; Im_o1 <= '0; Re_o2 <= '0;
      Im_o2 <= '0; Re_o3 <= '0; Im_o3 <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        Re_o1 <= d1_re;
        Im_o1 <= d1_im;
        Re_o2 <= re2_rs[bit_width-1:0];
        Im_o2 <= im2_rs[bit_width-1:0];
        Re_o3 <= re3_rs[bit_width-1:0];
        Im_o3 <= im3_rs[bit_width-1:0];
        ovf   <= re2_rs[bit_width] | im2_rs[bit_width] |
                 re3_rs[bit_width] | im3_rs[bit_width];
      end
    end
  end

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// tb/tb_twiddle_mult_stage.sv - self-checking bench for twiddle_mult_stage
module tb_twiddle_mult_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] Re_i1 = '0, Im_i1 = '0, Re_i2 = '0, Im_i2 = '0, Re_i3 = '0, Im_i3 = '0;
  logic [3:0]  tw_addr;
  logic [13:0] Re_w2 = '0, Im_w2 = '0, Re_w3 = '0, Im_w3 = '0;
  logic [15:0] Re_o1, Im_o1, Re_o2, Im_o2, Re_o3, Im_o3;
  logic        out_valid, ovf;

  twiddle_mult_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
    .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2),
    .Re_i3(Re_i3), .Im_i3(Im_i3), .tw_addr(tw_addr),
    .Re_w2(Re_w2), .Im_w2(Im_w2), .Re_w3(Re_w3), .Im_w3(Im_w3),
    .Re_o1(Re_o1), .Im_o1(Im_o1), .Re_o2(Re_o2), .Im_o2(Im_o2),
    .Re_o3(Re_o3), .Im_o3(Im_o3), .out_valid(out_valid), .ovf(ovf)
  );

  // Synchronous ROM: the word for tw_addr is latched at the edge.
  logic [13:0] rom_re2 [16], rom_im2 [16], rom_re3 [16], rom_im3 [16];
  always @(posedge clk) begin
    Re_w2 <= rom_re2[tw_addr];
    Im_w2 <= rom_im2[tw_addr];
    Re_w3 <= rom_re3[tw_addr];
    Im_w3 <= rom_im3[tw_addr];
  end

  typedef struct {
    int a1r, a1i, a2r, a2i, a3r, a3i;
    int w2r, w2i, w3r, w3i;
    int e1r, e1i, e2r, e2i, e3r, e3i;
    bit eovf;
  } vec_t;

  typedef struct {
    logic [95:0] d;
    bit          ov;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          k_model = 0;
  logic [95:0] last_out = '0;
  wire  [95:0] outs = {Re_o1, Im_o1, Re_o2, Im_o2, Re_o3, Im_o3};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [95:0] pack6(input int a, b, c, d, e, f);
    return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f)};
  endfunction

  function automatic void rnd_sat(input longint p, output int r, output bit o);
    longint t;
    t = (p + 2048) >>> 12;
    o = 1'b0;
    if (t > 32767) begin t = 32767; o = 1'b1; end
    else if (t < -32768) begin t = -32768; o = 1'b1; end
    r = int'(t);
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   o0, o1, o2, o3;
    r = v;
    r.e1r = v.a1r;
    r.e1i = v.a1i;
    rnd_sat(longint'(v.a2r) * v.w2r - longint'(v.a2i) * v.w2i, r.e2r, o0);
    rnd_sat(longint'(v.a2r) * v.w2i + longint'(v.a2i) * v.w2r, r.e2i, o1);
    rnd_sat(longint'(v.a3r) * v.w3r - longint'(v.a3i) * v.w3i, r.e3r, o2);
    rnd_sat(longint'(v.a3r) * v.w3i + longint'(v.a3i) * v.w3r, r.e3i, o3);
    r.eovf = o0 | o1 | o2 | o3;
    return r;
  endfunction

  function automatic int rs16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic int rtw();
    return int'($urandom_range(8192)) - 4096;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = '{rs16(), rs16(), rs16(), rs16(), rs16(), rs16(),
          rtw(), rtw(), rtw(), rtw(), 0, 0, 0, 0, 0, 0, 1'b0};
    return model(v);
  endfunction

  task automatic drive(input vec_t v, input bit fs, output int seen);
    int   k_exp;
    exp_t e;
    @(negedge clk);
    k_exp = fs ? 0 : k_model;
    rom_re2[k_exp] = 14'(v.w2r);
    rom_im2[k_exp] = 14'(v.w2i);
    rom_re3[k_exp] = 14'(v.w3r);
    rom_im3[k_exp] = 14'(v.w3i);
    in_valid = 1'b1;
    frame_start = fs;
    Re_i1 = 16'(v.a1r); Im_i1 = 16'(v.a1i);
    Re_i2 = 16'(v.a2r); Im_i2 = 16'(v.a2i);
    Re_i3 = 16'(v.a3r); Im_i3 = 16'(v.a3i);
    #1;
    seen = int'(tw_addr);
    check("tw_addr", tw_addr, k_exp);
    e.d   = pack6(v.e1r, v.e1i, v.e2r, v.e2i, v.e3r, v.e3i);
    e.ov  = v.eovf;
    e.cyc = cyc + 3;
    sbq.push_back(e);
    k_model = (k_exp + 1) % 16;
  endtask

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0;
    frame_start = 1'($urandom_range(1));
    Re_i2 = 16'($urandom); Im_i3 = 16'($urandom);
    #1;
    check("tw_addr_idle", tw_addr, k_model);
  endtask

  // Output monitor: pops the scoreboard on out_valid, checks hold otherwise.
  always @(posedge clk) begin
    logic r;
    exp_t e;
    r = rst;
    #1;
    if (r) begin
      check("reset_state", {out_valid, ovf, outs}, '0);
      last_out = '0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = sbq.pop_front();
        check("data", outs, e.d);
        check("ovf", ovf, e.ov);
        check("latency", cyc, e.cyc);
        last_out = outs;
      end
    end else begin
      check("hold", outs, last_out);
    end
  end

  vec_t tbl[$];
  int   seen;

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_re2[i] = '0; rom_im2[i] = '0; rom_re3[i] = '0; rom_im3[i] = '0;
    end

    // Reset with inputs toggling
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1));
      frame_start = 1'($urandom_range(1));
      Re_i1 = 16'($urandom); Im_i2 = 16'($urandom); Re_i3 = 16'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("tw_addr_after_reset", tw_addr, 4'd0);
    k_model = 0;

    // Hand vectors: identity, rotation, rounding, saturation both signs
    tbl.push_back('{7, 9, 1000, -500, 0, 0, 4096, 0, 0, 0,
                    7, 9, 1000, -500, 0, 0, 1'b0});
    tbl.push_back('{-5, 3, 0, 0, 300, 200, 0, 0, 0, -4096,
                    -5, 3, 0, 0, 200, -300, 1'b0});
    tbl.push_back('{1, 2, 3, -3, 0, 0, 2048, 0, 0, 0,
                    1, 2, 2, -1, 0, 0, 1'b0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 2048, 0, 0, 0,
                    0, 0, 1, 0, 0, 0, 1'b0});
    tbl.push_back('{11, 12, 32767, 32767, 0, 0, 4096, 4096, 0, 0,
                    11, 12, 0, 32767, 0, 0, 1'b1});
    tbl.push_back('{-1, -2, 1000, -500, 0, 0, 4096, 0, 0, 0,
                    -1, -2, 1000, -500, 0, 0, 1'b0});
    tbl.push_back('{0, 0, 0, 0, -32768, -32768, 0, 0, 4096, 4096,
                    0, 0, 0, 0, 0, -32768, 1'b1});
    for (int i = 0; i < 8; i++) tbl.push_back(rand_vec());

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 6 && $urandom_range(1) == 1) bubble();
      drive(tbl[i], i == 0, seen);
    end
    for (int i = 0; i < 4; i++) bubble();

    // Indexing across a wrap, frame_start on the first sample only
    for (int i = 0; i < 18; i++) begin
      if ($urandom_range(2) == 0) bubble();
      drive(rand_vec(), i == 0, seen);
      check("index_seq", seen, i % 16);
    end
    drive(rand_vec(), 1'b1, seen);
    check("frame_start_restart", seen, 0);
    drive(rand_vec(), 1'b0, seen);
    check("after_restart", seen, 1);
    for (int i = 0; i < 4; i++) bubble();

    // Reset with two samples in flight: neither may emerge
    drive(rand_vec(), 1'b0, seen);
    drive(rand_vec(), 1'b0, seen);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    k_model = 0;
    #1;
    check("tw_addr_post_flush", tw_addr, 4'd0);
    for (int i = 0; i < 5; i++) bubble();

    // One sample after the flush must come through normally
    drive(rand_vec(), 1'b0, seen);
    for (int i = 0; i < 6; i++) bubble();
    check("scoreboard_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/twiddle_mult_stage.md
# twiddle_mult_stage

Pipelined complex twiddle multiplier feeding the three-input combining adder stage of the parallel FFT datapath. Each valid input carries three complex samples. Sample 1 passes through delay-matched. Samples 2 and 3 are multiplied by twiddles W^k and W^(2k), which an external synchronous ROM supplies. All three results leave as registered, rounded and saturated words on a common valid strobe, and `out_valid` drives the downstream adder's `en`.

## Interface
- `bit_width`, default 16: data word width, signed two's complement, per real/imag part.
- `word_length_tw`, default 14: twiddle width, signed, format Q2.(word_length_tw-2), so 1.0 = 2^(word_length_tw-2) (4096 at default).
- `frame_len`, default 16: twiddle index count per frame, a power of two.
- `addr_w`, default 4: log2(frame_len).
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: the input triple is valid this cycle.
- `frame_start`  in  1: qualified by `in_valid`; this sample uses index k=0.
- `Re_i1`, `Im_i1`, `Re_i2`, `Im_i2`, `Re_i3`, `Im_i3`  in  bit_width each: input samples 1..3.
- `tw_addr`  out  addr_w: combinational twiddle index k for the current `in_valid` sample.
- `Re_w2`, `Im_w2`, `Re_w3`, `Im_w3`  in  word_length_tw each: ROM data (W^k, W^(2k)), valid one cycle after `tw_addr`.
- `Re_o1`, `Im_o1`, `Re_o2`, `Im_o2`, `Re_o3`, `Im_o3`  out  bit_width each: registered results.
- `out_valid`  out  1: the results are valid; connects to the adder's `en`.
- `ovf`  out  1: qualified by `out_valid`; saturation occurred in any part of this triple.

## Operation
- Index counter k, addr_w bits:
  - `tw_addr` = 0 when `frame_start`&`in_valid`, else k.
  - On each accepted sample, k <= `tw_addr`+1, wrapping frame_len-1 -> 0.
  - k holds when `in_valid`=0.
- Stage S0, on the edge of the `in_valid` cycle: register all six input parts and a valid bit.
- Stage S1:
  - Form the four real products per complex multiply, using the S0 data and the ROM data present in that cycle.
  - Each product is bit_width+word_length_tw bits, signed; register them. Register sample 1 as a delay copy.
- Stage S2, per complex multiply (a+jb)(c+jd):
  - re = ac-bd and im = ad+bc, at full width +1 bit.
  - Add 2^(word_length_tw-3) (round half toward +inf), then arithmetic shift right by word_length_tw-2.
  - Saturate to [-2^(bit_width-1), 2^(bit_width-1)-1] and register.
  - Sample 1 is registered unchanged into `Re_o1`/`Im_o1`.
- `ovf` = OR of the saturation events of the 4 clipped results for that triple.
- No backpressure: the downstream stage accepts every `out_valid`. Input bubbles propagate as bubbles; throughput is one triple per clock.
- Outputs hold their last value when `out_valid`=0.

## Timing
- Latency: `in_valid` in cycle t gives `out_valid` high in cycle t+3, exactly one cycle per valid input.
- ROM contract: the ROM registers `tw_addr` on edge t; data is valid throughout cycle t+1 and is consumed there.
- Reset (`rst`=1 at an edge):
  - All outputs, pipeline data and valid bits become 0, and k becomes 0.
  - `tw_addr` reads 0 the following cycle.
  - Samples in flight are discarded. `out_valid` stays 0 until 3 cycles after the first post-reset `in_valid`.
- `frame_start` mid-frame restarts indexing at 0 immediately. `frame_start` without `in_valid` is ignored.
- Back-to-back valids at wrap: indices run ...,14,15,0,1 with no gap.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs toggling -> all outputs 0, `out_valid`=0, `ovf`=0, `tw_addr`=0.
- Identity: W2=4096+j0, i2=1000-j500, i1=7+j9 -> in cycle t+3, o2=1000-j500, o1=7+j9, `ovf`=0.
- Rotation: W3=0-j4096, i3=300+j200 -> o3=200-j300.
- Rounding: W2=2048+j0 with i2=3+j(-3) -> o2=2+j(-1). Then i2=1+j0 -> o2=1+j0.
- Saturation: W2=4096+j4096, i2=32767+j32767 -> o2=0+j32767, `ovf`=1 only in that valid cycle.
- Indexing: 18 valids with random bubbles, `frame_start` on #1 only -> `tw_addr` 0..15,0,1. Then assert `frame_start` on the next sample -> 0. Assert `rst` with 2 samples in flight -> those samples produce no `out_valid`.
